fp_add_scheduler: RTL and testbench

//  Shares one pipelined IEEE-754 single-precision FP adder among NUM_REQ requesters.

---
 rtl/fp_add_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/fp_add_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fp_add_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared FP field helpers and tag type for the FP adder scheduler
package fp_add_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int TAG_ID_W = 2;

    typedef logic [FP_W-1:0] fp_t;

    // One tag-pipeline stage: marks a live adder slot and who asked for it
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic logic fp_sign(input fp_t x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input fp_t x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    function automatic logic [MAN_W-1:0] fp_man(input fp_t x);
        return x[MAN_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with next-pointer output
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_next_ptr
);

    // Search ptr, ptr+1, ... and grant the first requester found
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             found;
        o_grant    = '0;
        o_next_ptr = i_ptr;
        idx        = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && !found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                o_next_ptr   = PTR_W'((int'(idx) + 1) % NUM_REQ);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// rtl/fp_add_scheduler.sv - credit-gated round-robin sharing of one pipelined FP adder
module fp_add_scheduler
    import fp_add_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 5,
    parameter int FIFO_DEPTH  = 8,
    parameter int ID_W        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic                    add_valid,
    output logic [FP_W-1:0]         add_a,
    output logic [FP_W-1:0]         add_b,
    input  logic [FP_W-1:0]         add_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_next_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_hs;
    logic               w_can_issue;
    int                 w_inflight;
    logic [ID_W-1:0]    w_gnt_id;
    fp_t                w_gnt_a;
    fp_t                w_gnt_b;
    fp_t                r_add_a;
    fp_t                r_add_b;

    // Stage 0 is the issue register (it drives add_valid); stage ADD_LATENCY meets add_result
    tag_t               r_tag [ADD_LATENCY+1];

    logic [ID_W-1:0]    r_fifo_id   [FIFO_DEPTH];
    fp_t                r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0]      r_wr;
    logic [AW-1:0]      r_rd;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Every live tag stage is a future FIFO entry, so it holds a credit
    always_comb begin
        w_inflight = 0;
        for (int i = 0; i <= ADD_LATENCY; i++) begin
            w_inflight = w_inflight + int'(r_tag[i].valid);
        end
        w_can_issue = (int'(r_count) + w_inflight) < FIFO_DEPTH;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_arb (
        .i_req      (req_valid),
        .i_en       (w_can_issue & reset),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;

    // Select the granted requester's ID and operands
    always_comb begin
        w_gnt_id = '0;
        w_gnt_a  = '0;
        w_gnt_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_id = ID_W'(i);
                w_gnt_a  = req_a[FP_W*i +: FP_W];
                w_gnt_b  = req_b[FP_W*i +: FP_W];
            end
        end
    end

    // Rotate the pointer and register operands on each handshake; operands hold otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_add_a <= '0;
            r_add_b <= '0;
        end else if (w_hs) begin
            r_ptr   <= w_next_ptr;
            r_add_a <= {fp_sign(w_gnt_a), fp_exp(w_gnt_a), fp_man(w_gnt_a)};
            r_add_b <= {fp_sign(w_gnt_b), fp_exp(w_gnt_b), fp_man(w_gnt_b)};
        end
    end

    assign add_valid = r_tag[0].valid;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;

    // Tag shift register; clearing it on reset discards results still inside the adder
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= ADD_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_hs;
            r_tag[0].id    <= TAG_ID_W'(w_gnt_id);
            for (int i = 1; i <= ADD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_push = r_tag[ADD_LATENCY].valid;
    assign w_pop  = rsp_valid & rsp_ready;

    // FIFO storage write; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr]   <= ID_W'(r_tag[ADD_LATENCY].id);
            r_fifo_data[r_wr] <= add_result;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rsp_valid = (r_count != '0);
    assign rsp_id    = rsp_valid ? r_fifo_id[r_rd]   : '0;
    assign rsp_data  = rsp_valid ? r_fifo_data[r_rd] : '0;

    // The credit rule must keep a non-popping push away from a full FIFO
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb/tb_fp_add_scheduler.sv - directed scoreboard bench for fp_add_scheduler
module tb_fp_add_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         add_valid;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic [31:0]  add_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0]  sb_q [$];
    int           grant_log [$];

    always #5 clk = ~clk;

    fp_add_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_valid  (add_valid),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    function automatic logic [63:0] sp2dp(input logic [31:0] s);
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        return {s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] dp2sp(input logic [63:0] d);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return dp2sp($realtobits($bitstoreal(sp2dp(a)) + $bitstoreal(sp2dp(b))));
    endfunction

    function automatic logic [31:0] int2fp(input int n);
        return dp2sp($realtobits(real'(n)));
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ops();
        for (int s = 0; s < 4; s++) begin
            req_a[32*s +: 32] = int2fp(int'($urandom_range(1, 1000)));
            req_b[32*s +: 32] = int2fp(int'($urandom_range(1, 1000)));
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((sb_q.size() != 0 || rsp_valid) && k < 100) begin
            tick();
            k++;
        end
        check("drain_empty", 128'(sb_q.size()), 128'd0);
    endtask

    // Five-stage behavioural adder; junk fills idle slots so stray captures show up
    logic [31:0] add_pipe [5];
    always @(posedge clk) begin
        add_pipe[0] <= add_valid ? fp_add(add_a, add_b) : 32'hDEADBEEF;
        for (int i = 1; i < 5; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_result = add_pipe[4];

    // Monitor: push expectations on handshakes, pop and compare on responses
    always @(negedge clk) begin
        if (reset) begin
            check("grant_onehot0", 128'($onehot0(req_ready)), 128'd1);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({2'(i), fp_add(req_a[32*i +: 32], req_b[32*i +: 32])});
                    grant_log.push_back(i);
                end
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) begin
                    check("rsp_id_data", 128'({rsp_id, rsp_data}), 128'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset     = 1'b0;
        req_valid = 4'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", 128'({req_ready, add_valid, add_a, add_b, rsp_valid, rsp_id, rsp_data}), 128'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single op: 98 + 169 = 267
        req_a[31:0] = 32'h42C40000;
        req_b[31:0] = 32'h43290000;
        req_valid   = 4'b0001;
        @(negedge clk);
        check("t1_ready", 128'(req_ready), 128'h1);
        tick();
        req_valid = 4'b0;
        @(negedge clk);
        check("t1_issue", 128'({add_valid, add_a, add_b}), 128'({1'b1, 32'h42C40000, 32'h43290000}));
        repeat (5) tick();
        @(negedge clk);
        check("t1_not_yet", 128'(rsp_valid), 128'd0);
        tick();
        @(negedge clk);
        check("t1_rsp", 128'({rsp_valid, rsp_id, rsp_data}), 128'({1'b1, 2'd0, 32'h43858000}));
        drain();

        // All requesters valid, no backpressure: one grant per cycle, rotating from ptr=1
        grant_log.delete();
        req_valid = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            randomize_ops();
            tick();
        end
        req_valid = 4'b0;
        check("t2_grant_count", 128'(grant_log.size()), 128'd16);
        for (int i = 0; i < 16 && i < grant_log.size(); i++) begin
            check("t2_grant_order", 128'(grant_log[i]), 128'((1 + i) % 4));
        end
        drain();

        // Backpressure: credits cap issue at the FIFO depth, then resume without loss
        grant_log.delete();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            randomize_ops();
            tick();
        end
        @(negedge clk);
        check("t3_handshakes", 128'(grant_log.size()), 128'd8);
        check("t3_stalled", 128'({req_ready, rsp_valid}), 128'({4'b0, 1'b1}));
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            randomize_ops();
            tick();
        end
        req_valid = 4'b0;
        check("t3_resumed", 128'(grant_log.size() > 8), 128'd1);
        drain();

        // Reset with three ops in flight: late results must never appear
        req_valid = 4'b1111;
        repeat (3) begin
            randomize_ops();
            tick();
        end
        req_valid = 4'b0;
        reset     = 1'b0;
        sb_q.delete();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_cleared", 128'({req_ready, add_valid, add_a, add_b, rsp_valid, rsp_id, rsp_data}), 128'd0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            seen = seen | rsp_valid;
        end
        check("t5_no_late_rsp", 128'(seen), 128'd0);

        // Pointer restarts at 0, then wraps from 3 back to 0
        randomize_ops();
        req_valid = 4'b1010;
        @(negedge clk);
        check("t6_ptr0", 128'(req_ready), 128'b0010);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        check("t6_req3", 128'(req_ready), 128'b1000);
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        check("t6_wrap", 128'(req_ready), 128'b0001);
        tick();
        req_valid = 4'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
